div_iter: RTL

Iterative 64-bit radix-2 restoring integer divider; the division counterpart to the Booth/Wallace multiplier in the execution unit's mul/div path. Accepts one signed or unsigned dividend/divisor pair over a valid/ready handshake. Produces quotient and remainder with RISC-V M-extension semantics after a fixed iteration count. Holds the result until the consumer takes it; the pipeline can abort an in-flight operation with a flush.

---
 rtl/div_iter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (RISC-V M semantics), one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero / signed overflow finish at the accept edge.
module div_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_valid/in_ready move the operand pair in; out_valid/out_ready move the result out.
    // out_valid stays high and the result is held until out_ready, unless flush or rst.

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, POST, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             accept;
    logic             special;

    assign in_ready = (state == IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    // Trial subtraction is WIDTH+1 bits wide; bit WIDTH set means the subtraction went negative.
    always_comb begin
        shifted = {part_rem, dq[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
    end

`ifdef DIV_FAST_SPECIAL_EN
    always_comb begin
        special = (divisor == '0) ||
                  (div_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1));
    end
`else
    assign special = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            part_rem  <= '0;
            dq        <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // A zero divisor must still yield an all-ones quotient, so no sign fix then.
                        q_neg    <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]) &&
                                    (divisor != '0);
                        r_neg    <= div_signed && dividend[WIDTH-1];
                        dq       <= (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                        dvs      <= (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                        part_rem <= '0;
                        count    <= '0;
                        if (special) begin
                            quotient  <= (divisor == '0) ? '1 : dividend;
                            remainder <= (divisor == '0) ? dividend : '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[WIDTH]) begin
                        part_rem <= diff[WIDTH-1:0];
                        dq       <= {dq[WIDTH-2:0], 1'b1};
                    end else begin
                        part_rem <= shifted[WIDTH-1:0];
                        dq       <= {dq[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= POST;
                    end
                end
                POST: begin
                    quotient  <= q_neg ? -dq : dq;
                    remainder <= r_neg ? -part_rem : part_rem;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
